// File: rtl/mem_arb_pkg.sv
// Shared types and RV32I funct3 width codes for the unified-memory arbiter.
package mem_arb_pkg;

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    typedef enum logic {
        OWN_IF,
        OWN_D
    } owner_t;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

endpackage

// File: rtl/mem_lsu_align.sv
// Combinational load/store lane handling: store byte enables and lane replication,
// load byte/halfword extraction with sign/zero extension, and misalignment detection.
module mem_lsu_align
    import mem_arb_pkg::*;
(
    input  logic [2:0]  st_funct3,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_wdata,
    output logic [3:0]  st_be,
    output logic [31:0] st_data,
    output logic        misaligned,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Replicating the data across lanes lets the memory pick it up under any enable pattern.
    always_comb begin
        st_be      = 4'b0000;
        st_data    = 32'h0;
        misaligned = 1'b0;
        case (st_funct3)
            F3_B, F3_BU: begin
                st_be   = 4'b0001 << st_off;
                st_data = {4{st_wdata[7:0]}};
            end
            F3_H, F3_HU: begin
                st_be      = st_off[1] ? 4'b1100 : 4'b0011;
                st_data    = {2{st_wdata[15:0]}};
                misaligned = st_off[0];
            end
            default: begin
                st_be      = 4'b1111;
                st_data    = st_wdata;
                misaligned = (st_off != 2'b00);
            end
        endcase
    end

    always_comb begin
        ld_byte = 8'h0;
        case (ld_off)
            2'd0: ld_byte = ld_rdata[7:0];
            2'd1: ld_byte = ld_rdata[15:8];
            2'd2: ld_byte = ld_rdata[23:16];
            2'd3: ld_byte = ld_rdata[31:24];
            default: ld_byte = 8'h0;
        endcase
        ld_half = ld_off[1] ? ld_rdata[31:16] : ld_rdata[15:0];
        case (ld_funct3)
            F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
            F3_BU:   ld_data = {24'h0, ld_byte};
            F3_HU:   ld_data = {16'h0, ld_half};
            default: ld_data = ld_rdata;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter sharing one memory between fetch and load/store, data first.
// Optional MEMARB_TIMEOUT_EN aborts a WAIT that lasts TIMEOUT cycles without mem_rvalid.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = 64
)
(
    input  logic        clk,
    input  logic        n_rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [2:0]  d_funct3,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        mem_req,
    input  logic        mem_gnt,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    state_t      state;
    owner_t      owner;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic        we_q;
    logic        err_q;

    logic        idle_free;
    logic        d_sel;
    logic        if_sel;
    logic        d_misaligned;
    logic        timeout_hit;
    logic        resp_fire;
    logic [3:0]  st_be;
    logic [31:0] st_data;
    logic [31:0] ld_data;

    mem_lsu_align u_align (
        .st_funct3  (d_funct3),
        .st_off     (d_addr[1:0]),
        .st_wdata   (d_wdata),
        .st_be      (st_be),
        .st_data    (st_data),
        .misaligned (d_misaligned),
        .ld_funct3  (f3_q),
        .ld_off     (off_q),
        .ld_rdata   (mem_rdata),
        .ld_data    (ld_data)
    );

    // The cycle that reports a misaligned access also blocks arbitration.
    assign idle_free = (state == IDLE) && !err_q;
    assign d_sel     = idle_free && d_req && !d_misaligned;
    assign if_sel    = idle_free && !d_req && if_req;

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'h0;
        mem_be    = 4'b0000;
        mem_wdata = 32'h0;
        if (d_sel) begin
            mem_req   = 1'b1;
            mem_we    = d_we;
            mem_addr  = d_addr & 32'hFFFF_FFFC;
            mem_be    = st_be;
            mem_wdata = d_we ? st_data : 32'h0;
        end else if (if_sel) begin
            mem_req   = 1'b1;
            mem_addr  = if_addr & 32'hFFFF_FFFC;
            mem_be    = 4'b1111;
        end
    end

    assign d_gnt  = d_sel && mem_gnt;
    assign if_gnt = if_sel && mem_gnt;

`ifdef MEMARB_TIMEOUT_EN
    logic [31:0] wait_cnt;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wait_cnt <= 32'h0;
        end else if (state == IDLE) begin
            wait_cnt <= 32'h0;
        end else begin
            wait_cnt <= wait_cnt + 32'h1;
        end
    end

    assign timeout_hit = (state == WAIT) && !mem_rvalid && (wait_cnt == 32'(TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    assign resp_fire = (state == WAIT) && (mem_rvalid || timeout_hit);
    assign busy      = (state == WAIT);

    assign if_rvalid = resp_fire && (owner == OWN_IF);
    assign if_rdata  = ((state == WAIT) && (owner == OWN_IF) && mem_rvalid) ? mem_rdata : 32'h0;
    assign d_rvalid  = (resp_fire && (owner == OWN_D)) || err_q;
    assign d_err     = err_q || (timeout_hit && (owner == OWN_D));
    assign d_rdata   = ((state == WAIT) && (owner == OWN_D) && mem_rvalid && !we_q) ? ld_data : 32'h0;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
            owner <= OWN_IF;
            f3_q  <= F3_B;
            off_q <= 2'b00;
            we_q  <= 1'b0;
            err_q <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (idle_free && d_req && d_misaligned) begin
                        err_q <= 1'b1;
                    end else if (mem_req && mem_gnt) begin
                        owner <= d_sel ? OWN_D : OWN_IF;
                        f3_q  <= d_funct3;
                        off_q <= d_addr[1:0];
                        we_q  <= d_sel && d_we;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (resp_fire) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a behavioural memory answers one cycle after grant,
// expected responses are queued at issue and checked when the DUT responds.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } d_exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  f3;
        logic [31:0] word;
        logic [31:0] exp;
    } ld_vec_t;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'h0;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = 32'h0;
    logic [31:0] d_wdata = 32'h0;
    logic [2:0]  d_funct3 = 3'd0;
    logic        d_gnt, d_rvalid, d_err;
    logic [31:0] d_rdata;
    logic        mem_req, mem_we;
    logic        mem_gnt = 1'b1;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        busy;

    d_exp_t      exp_d_q[$];
    logic [31:0] exp_if_q[$];
    int          checks = 0;
    int          fails = 0;

    logic [31:0] mem_arr [0:255];
    logic        resp_en = 1'b1;
    logic        late_pulse = 1'b0;
    logic        mm_hit, mm_we;
    logic [31:0] mm_addr, mm_wdata;
    logic [3:0]  mm_be;
    d_exp_t      mon_e;
    logic [31:0] mon_i;

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT(4)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_funct3   (d_funct3),
        .d_gnt      (d_gnt),
        .d_rvalid   (d_rvalid),
        .d_rdata    (d_rdata),
        .d_err      (d_err),
        .mem_req    (mem_req),
        .mem_gnt    (mem_gnt),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .busy       (busy)
    );

    // Memory model: sample the request mid-cycle, answer just after the next edge.
    always begin
        @(negedge clk);
        mm_hit   = mem_req && mem_gnt && n_rst;
        mm_we    = mem_we;
        mm_addr  = mem_addr;
        mm_wdata = mem_wdata;
        mm_be    = mem_be;
        @(posedge clk);
        #1;
        if (mm_hit && mm_we) begin
            for (int i = 0; i < 4; i++) begin
                if (mm_be[i]) mem_arr[mm_addr[9:2]][8*i +: 8] = mm_wdata[8*i +: 8];
            end
        end
        mem_rvalid = (mm_hit && resp_en) || late_pulse;
        mem_rdata  = (mm_hit && resp_en && !mm_we) ? mem_arr[mm_addr[9:2]] : 32'hDEAD_BEEF;
    end

    // Scoreboard monitor: every response must match the oldest queued expectation.
    always @(negedge clk) begin
        if (n_rst) begin
            if (d_rvalid) begin
                checks++;
                if (exp_d_q.size() == 0) begin
                    fails++;
                    $display("[TB] FAIL d_resp_unexpected: got rdata=%h err=%b, expected no response", d_rdata, d_err);
                end else begin
                    mon_e = exp_d_q.pop_front();
                    if ({d_rdata, d_err} !== {mon_e.rdata, mon_e.err}) begin
                        fails++;
                        $display("[TB] FAIL d_resp: got rdata=%h err=%b, expected rdata=%h err=%b",
                                 d_rdata, d_err, mon_e.rdata, mon_e.err);
                    end
                end
            end
            if (if_rvalid) begin
                checks++;
                if (exp_if_q.size() == 0) begin
                    fails++;
                    $display("[TB] FAIL if_resp_unexpected: got rdata=%h, expected no response", if_rdata);
                end else begin
                    mon_i = exp_if_q.pop_front();
                    if (if_rdata !== mon_i) begin
                        fails++;
                        $display("[TB] FAIL if_resp: got rdata=%h, expected %h", if_rdata, mon_i);
                    end
                end
            end
            if (if_gnt) begin
                checks++;
                if (busy !== 1'b0) begin
                    fails++;
                    $display("[TB] FAIL if_gnt_while_busy: busy=%b, expected 0", busy);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic d_drive(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [2:0] f3);
        d_req    = 1'b1;
        d_we     = we;
        d_addr   = addr;
        d_wdata  = wdata;
        d_funct3 = f3;
    endtask

    task automatic wait_d(input int max_cycles, input string name);
        int n = 1;
        @(negedge clk);
        while (!d_rvalid && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (d_rvalid !== 1'b1) begin
            fails++;
            $display("[TB] FAIL %s: got no d_rvalid, expected one within %0d cycles", name, max_cycles);
        end
        @(posedge clk);
        #1;
        d_req = 1'b0;
        d_we  = 1'b0;
    endtask

    task automatic wait_if(input int max_cycles, input string name);
        int n = 1;
        @(negedge clk);
        while (!if_rvalid && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (if_rvalid !== 1'b1) begin
            fails++;
            $display("[TB] FAIL %s: got no if_rvalid, expected one within %0d cycles", name, max_cycles);
        end
        @(posedge clk);
        #1;
        if_req = 1'b0;
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({if_gnt, if_rvalid, d_gnt, d_rvalid, d_err, mem_req, mem_we, busy, mem_be} !== 12'h0) begin
            fails++;
            $display("[TB] FAIL reset_flags: got %b, expected 0",
                     {if_gnt, if_rvalid, d_gnt, d_rvalid, d_err, mem_req, mem_we, busy, mem_be});
        end
        checks++;
        if ({mem_addr, mem_wdata, d_rdata, if_rdata} !== 128'h0) begin
            fails++;
            $display("[TB] FAIL reset_data: got %h, expected 0", {mem_addr, mem_wdata, d_rdata, if_rdata});
        end
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, mem_req, d_rvalid, if_rvalid} !== 4'b0) begin
            fails++;
            $display("[TB] FAIL post_reset_idle: got %b, expected 0000", {busy, mem_req, d_rvalid, if_rvalid});
        end
    endtask

    task automatic test_fetch();
        mem_arr[4] = 32'h0050_0093;
        @(posedge clk);
        #1;
        if_req  = 1'b1;
        if_addr = 32'h10;
        exp_if_q.push_back(32'h0050_0093);
        @(negedge clk);
        checks++;
        if ({if_gnt, mem_req, mem_we, busy, mem_be, mem_addr} !== {4'b1100, 4'hF, 32'h10}) begin
            fails++;
            $display("[TB] FAIL fetch_req: got gnt/req/we/busy=%b be=%b addr=%h, expected 1100 1111 00000010",
                     {if_gnt, mem_req, mem_we, busy}, mem_be, mem_addr);
        end
        @(negedge clk);
        checks++;
        if ({if_rvalid, busy, mem_req} !== 3'b110) begin
            fails++;
            $display("[TB] FAIL fetch_resp_cycle: got rvalid/busy/req=%b, expected 110", {if_rvalid, busy, mem_req});
        end
        @(posedge clk);
        #1;
        if_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, if_rvalid} !== 2'b00) begin
            fails++;
            $display("[TB] FAIL fetch_after: got busy/rvalid=%b, expected 00", {busy, if_rvalid});
        end
    endtask

    task automatic test_priority();
        mem_arr[8'h40] = 32'h1234_5678;
        mem_arr[8]     = 32'hCAFE_0013;
        @(posedge clk);
        #1;
        if_req  = 1'b1;
        if_addr = 32'h20;
        d_drive(1'b0, 32'h100, 32'h0, F3_W);
        exp_d_q.push_back('{32'h1234_5678, 1'b0});
        exp_if_q.push_back(32'hCAFE_0013);
        @(negedge clk);
        checks++;
        if ({d_gnt, if_gnt, mem_addr} !== {2'b10, 32'h100}) begin
            fails++;
            $display("[TB] FAIL priority_grant: got d_gnt/if_gnt=%b addr=%h, expected 10 00000100",
                     {d_gnt, if_gnt}, mem_addr);
        end
        wait_d(8, "priority_d_resp");
        @(negedge clk);
        checks++;
        if ({if_gnt, mem_addr} !== {1'b1, 32'h20}) begin
            fails++;
            $display("[TB] FAIL priority_if_next: got if_gnt=%b addr=%h, expected 1 00000020", if_gnt, mem_addr);
        end
        wait_if(8, "priority_if_resp");
    endtask

    task automatic test_store();
        mem_arr[8'h80] = 32'h0;
        @(posedge clk);
        #1;
        d_drive(1'b1, 32'h203, 32'h0000_00AB, F3_B);
        exp_d_q.push_back('{32'h0, 1'b0});
        @(negedge clk);
        checks++;
        if ({mem_we, mem_be, mem_wdata, mem_addr} !== {1'b1, 4'b1000, 32'hABAB_ABAB, 32'h200}) begin
            fails++;
            $display("[TB] FAIL sb_lanes: got we=%b be=%b wdata=%h addr=%h, expected 1 1000 ababab ab 00000200",
                     mem_we, mem_be, mem_wdata, mem_addr);
        end
        wait_d(8, "sb_ack");
        @(posedge clk);
        #1;
        d_drive(1'b1, 32'h202, 32'h0000_1234, F3_H);
        exp_d_q.push_back('{32'h0, 1'b0});
        @(negedge clk);
        checks++;
        if ({mem_be, mem_wdata} !== {4'b1100, 32'h1234_1234}) begin
            fails++;
            $display("[TB] FAIL sh_lanes: got be=%b wdata=%h, expected 1100 12341234", mem_be, mem_wdata);
        end
        wait_d(8, "sh_ack");
        @(posedge clk);
        #1;
        d_drive(1'b0, 32'h200, 32'h0, F3_W);
        exp_d_q.push_back('{32'h1234_0000, 1'b0});
        @(negedge clk);
        checks++;
        if ({mem_we, mem_be} !== {1'b0, 4'b1111}) begin
            fails++;
            $display("[TB] FAIL lw_be: got we=%b be=%b, expected 0 1111", mem_we, mem_be);
        end
        wait_d(8, "lw_readback");
    endtask

    task automatic test_load();
        ld_vec_t vecs[6];
        vecs[0] = '{32'h101, F3_B,  32'h0000_F000, 32'hFFFF_FFF0};
        vecs[1] = '{32'h101, F3_BU, 32'h0000_F000, 32'h0000_00F0};
        vecs[2] = '{32'h102, F3_HU, 32'h8001_5A5A, 32'h0000_8001};
        vecs[3] = '{32'h102, F3_H,  32'h8001_5A5A, 32'hFFFF_8001};
        vecs[4] = '{32'h100, F3_H,  32'h8001_7FFF, 32'h0000_7FFF};
        vecs[5] = '{32'h103, F3_B,  32'h7F00_0000, 32'h0000_007F};
        for (int i = 0; i < 6; i++) begin
            mem_arr[vecs[i].addr[9:2]] = vecs[i].word;
            @(posedge clk);
            #1;
            d_drive(1'b0, vecs[i].addr, 32'h0, vecs[i].f3);
            exp_d_q.push_back('{vecs[i].exp, 1'b0});
            @(negedge clk);
            wait_d(8, "load_vec");
        end
    endtask

    task automatic test_misaligned();
        mem_arr[12] = 32'h0000_0013;
        @(posedge clk);
        #1;
        if_req  = 1'b1;
        if_addr = 32'h30;
        d_drive(1'b0, 32'h102, 32'h0, F3_W);
        exp_d_q.push_back('{32'h0, 1'b1});
        exp_if_q.push_back(32'h0000_0013);
        @(negedge clk);
        checks++;
        if ({mem_req, if_gnt} !== 2'b00) begin
            fails++;
            $display("[TB] FAIL misalign_noreq: got req/if_gnt=%b, expected 00", {mem_req, if_gnt});
        end
        @(negedge clk);
        checks++;
        if ({d_rvalid, mem_req, if_gnt} !== 3'b100) begin
            fails++;
            $display("[TB] FAIL misalign_resp: got rvalid/req/if_gnt=%b, expected 100", {d_rvalid, mem_req, if_gnt});
        end
        @(posedge clk);
        #1;
        d_req = 1'b0;
        @(negedge clk);
        checks++;
        if (if_gnt !== 1'b1) begin
            fails++;
            $display("[TB] FAIL misalign_if_after: got if_gnt=%b, expected 1", if_gnt);
        end
        wait_if(8, "misalign_if_resp");
        @(posedge clk);
        #1;
        d_drive(1'b1, 32'h201, 32'h5555, F3_H);
        exp_d_q.push_back('{32'h0, 1'b1});
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0) begin
            fails++;
            $display("[TB] FAIL sh_misalign_noreq: got mem_req=%b, expected 0", mem_req);
        end
        wait_d(8, "sh_misalign_resp");
    endtask

`ifdef MEMARB_TIMEOUT_EN
    task automatic test_timeout();
        int n = 0;
        @(negedge clk);
        resp_en = 1'b0;
        @(posedge clk);
        #1;
        d_drive(1'b0, 32'h100, 32'h0, F3_W);
        exp_d_q.push_back('{32'h0, 1'b1});
        @(negedge clk);
        while (!d_rvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if ({n, busy} !== {32'd4, 1'b1}) begin
            fails++;
            $display("[TB] FAIL timeout_latency: got %0d wait cycles busy=%b, expected 4 busy=1", n, busy);
        end
        late_pulse = 1'b1;
        @(posedge clk);
        #1;
        d_req = 1'b0;
        @(negedge clk);
        late_pulse = 1'b0;
        checks++;
        if ({d_rvalid, if_rvalid, busy} !== 3'b000) begin
            fails++;
            $display("[TB] FAIL timeout_late_rvalid: got rvalid/if/busy=%b, expected 000", {d_rvalid, if_rvalid, busy});
        end
        resp_en = 1'b1;
    endtask
`endif

    task automatic test_reset_mid_wait();
`ifdef MEMARB_TIMEOUT_EN
        int hold = 2;
`else
        int hold = 10;
`endif
        @(negedge clk);
        resp_en = 1'b0;
        @(posedge clk);
        #1;
        d_drive(1'b0, 32'h100, 32'h0, F3_W);
        @(negedge clk);
        checks++;
        if (d_gnt !== 1'b1) begin
            fails++;
            $display("[TB] FAIL hang_grant: got d_gnt=%b, expected 1", d_gnt);
        end
        repeat (hold) @(negedge clk);
        checks++;
        if ({busy, d_rvalid} !== 2'b10) begin
            fails++;
            $display("[TB] FAIL hang_busy: got busy/rvalid=%b after %0d cycles, expected 10", {busy, d_rvalid}, hold);
        end
        @(posedge clk);
        #1;
        n_rst = 1'b0;
        d_req = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_mid_wait: got busy=%b, expected 0", busy);
        end
        @(negedge clk);
        late_pulse = 1'b1;
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        @(negedge clk);
        late_pulse = 1'b0;
        checks++;
        if ({d_rvalid, if_rvalid, busy} !== 3'b000) begin
            fails++;
            $display("[TB] FAIL late_rvalid_idle: got rvalid/if/busy=%b, expected 000", {d_rvalid, if_rvalid, busy});
        end
        resp_en = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem_arr[i] = 32'h0;
        $display("[TB] starting mem_arbiter bench");
        test_reset();
        test_fetch();
        test_priority();
        test_store();
        test_load();
        test_misaligned();
`ifdef MEMARB_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid_wait();
        repeat (3) @(negedge clk);
        checks++;
        if ((exp_d_q.size() + exp_if_q.size()) != 0) begin
            fails++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending responses, expected 0",
                     exp_d_q.size() + exp_if_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter and sequencer that shares one unified instruction/data memory between the core's instruction fetch and its load/store path. It sits between the fetch/PC logic, the execute stage's load/store signals (address from ALU result, store data from rd2, funct3), and a single request/response memory port. It also performs store byte-lane alignment, load extraction/extension and misalignment checking.

## Interface
Parameters:
- TIMEOUT, 64: cycles to wait for `mem_rvalid` before aborting (used only with the timeout feature).

Ports:
- clk  in  1  core clock; every register in this block updates on its rising edge.
- n_rst  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held until `if_rvalid`.
- if_addr  in  32  fetch address; word-aligned.
- if_gnt  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  fetch response valid; one cycle.
- if_rdata  out  32  instruction word.
- d_req  in  1  load/store request; held until `d_rvalid`.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  32  byte address.
- d_wdata  in  32  store data, right-justified.
- d_funct3  in  3  RV32I width and sign code: 0 LB/SB, 1 LH/SH, 2 LW/SW, 4 LBU, 5 LHU.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  data response valid; one cycle.
- d_rdata  out  32  extended load data; 0 for stores.
- d_err  out  1  error qualifier, valid with `d_rvalid`.
- mem_req  out  1  memory request.
- mem_gnt  in  1  memory accepts request this cycle.
- mem_we  out  1  write.
- mem_addr  out  32  word address, byte address with bits [1:0] cleared.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-aligned store data.
- mem_rvalid  in  1  memory response.
- mem_rdata  in  32  memory read word.
- busy  out  1  a transaction is outstanding.

## Operation
- FSM states are IDLE and WAIT. At most one transaction is outstanding.
- **IDLE arbitration:**
  - Fixed priority, data over fetch. The data request belongs to the instruction already in flight, so fetch waits.
  - The chosen requester drives `mem_*` combinationally.
  - The winner's gnt = `mem_gnt`. The loser's gnt = 0.
  - On `mem_gnt`: register the owner (IF or D), funct3 and addr[1:0], then go to WAIT.
- **WAIT:**
  - `mem_req` = 0.
  - On `mem_rvalid`: forward the response combinationally to the owner only, then go to IDLE.
  - No new request is issued in the same cycle as `mem_rvalid`.
- **Misaligned data access:** LH/LHU/SH with addr[0] = 1, or LW/SW with addr[1:0] ≠ 0.
  - No memory request is made.
  - In the next cycle: `d_rvalid` = 1, `d_err` = 1, `d_rdata` = 0.
  - Fetch remains blocked during that cycle.
- **Stores:**
  - SB: `mem_be` = 1 << addr[1:0], data = byte replicated ×4.
  - SH: `mem_be` = 0011 or 1100 (by addr[1]), data = halfword replicated ×2.
  - SW: `mem_be` = 1111.
  - The memory acknowledges stores with `mem_rvalid`.
  - `d_rvalid` is asserted on the ack, with `d_rdata` = 0.
- **Loads:**
  - Select the byte or halfword using the registered addr[1:0].
  - Sign-extend for funct3 0/1; zero-extend for funct3 4/5; LW passes the word through.
- **Fetch:** `mem_be` = 1111, `mem_we` = 0.
- `mem_rvalid` arriving in IDLE is ignored.
- `busy` = (state == WAIT).

## Timing
- **Reset values:** state IDLE; all outputs 0 except the combinational `mem_*` and gnt paths, which follow their inputs. After reset with no requests, these are also 0.
- **Minimum latency:** request-to-response is 2 cycles (gnt in cycle N, rvalid earliest in N+1). Back-to-back grants are at best every 2 cycles.
- **Simultaneous `if_req` and `d_req`:** D is granted. IF is granted in the first IDLE cycle after D's response.
- **Reset asserted mid-WAIT:** the FSM returns to IDLE immediately and the owner is cleared. A late `mem_rvalid` is ignored.

## Configuration
- MEMARB_TIMEOUT_EN defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT without `mem_rvalid`, the owner receives rvalid with rdata = 0. `d_err` = 1 for D; fetch errors are not flagged.
  - The FSM then goes to IDLE. A late `mem_rvalid` is ignored.
- Undefined: WAIT holds indefinitely, and `d_err` signals misalignment only.

## Structure
- Package mem_arb_pkg: state enum (IDLE, WAIT), owner enum (OWN_IF, OWN_D), funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU).
- Sub-module mem_lsu_align (combinational): store lane/be generation, load extraction/extension, misalignment detect.
- The FSM, owner register and timeout counter live in mem_arbiter.

## Test plan
- Fetch only, if_addr = 0x10, memory answers 1 cycle after gnt with 0x00500093 → if_gnt in cycle 0, if_rvalid with if_rdata = 0x00500093 in cycle 1, busy high in cycle 1 only.
- if_req and d_req (LW 0x100) asserted together → d_gnt first, D response, then if_gnt in the following IDLE cycle; if_gnt never asserted while busy.
- SB d_addr = 0x203, d_wdata = 0xAB → mem_be = 1000, mem_wdata = 0xABABABAB, mem_addr = 0x200; SH 0x202 → be = 1100.
- LB at 0x101 with mem_rdata = 0x0000F000 → d_rdata = 0xFFFFFFF0. LBU at the same address → 0x000000F0. LHU at 0x102 with rdata = 0x8001xxxx → 0x00008001.
- LW at 0x102 → no mem_req; next cycle d_rvalid = 1, d_err = 1, d_rdata = 0.
- With MEMARB_TIMEOUT_EN and TIMEOUT = 4, D load, no rvalid → d_rvalid with d_err = 1 after 4 WAIT cycles; a late mem_rvalid produces no output. Without the macro, busy stays high.
